// File: rtl/fft_stage2_serial_if.sv
// Bus between FFT stage 1 and stage 2: start strobe, eight complex inputs,
// eight complex registered results and the status flags.
interface fft_stage2_serial_if #(
    parameter int DW = 12
);
    logic                 stage1_done;
    logic signed [DW-1:0] x_stage1_real  [0:7];
    logic signed [DW-1:0] x_stage1_image [0:7];
    logic signed [DW-1:0] x_stage2_real  [0:7];
    logic signed [DW-1:0] x_stage2_image [0:7];
    logic                 stage2_done;
    logic                 busy;
    logic                 overrun;

    modport master (
        output stage1_done, x_stage1_real, x_stage1_image,
        input  x_stage2_real, x_stage2_image, stage2_done, busy, overrun
    );

    modport slave (
        input  stage1_done, x_stage1_real, x_stage1_image,
        output x_stage2_real, x_stage2_image, stage2_done, busy, overrun
    );
endinterface

// File: rtl/fft_stage2_serial.sv
// Second DIF stage of the 8-point FFT: four radix-2 butterflies evaluated
// serially through one shared datapath, one butterfly per clock.
module fft_stage2_serial #(
    parameter int DW = 12
) (
    input  logic              CLK,
    input  logic              RESET,
    fft_stage2_serial_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

    state_t               state_reg, state_next;
    logic [1:0]           cnt_reg, cnt_next;
    logic signed [DW-1:0] cap_re_reg [0:7];
    logic signed [DW-1:0] cap_im_reg [0:7];
    logic signed [DW-1:0] out_re_reg [0:7];
    logic signed [DW-1:0] out_im_reg [0:7];
    logic                 done_reg;
    logic                 overrun_reg;

    logic                 accept;
    logic                 calc_en;
    logic                 last;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        calc_en    = 1'b0;
        last       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.stage1_done) begin
                    accept     = 1'b1;
                    cnt_next   = 2'd0;
                    state_next = CALC;
                end
            end
            CALC: begin
                calc_en  = 1'b1;
                cnt_next = cnt_reg + 2'd1;
                if (cnt_reg == 2'd3) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Butterfly k pairs x[a] with x[a+2], a in {0,1,4,5}; odd k carries the -j twiddle.
    logic [2:0]           idx_a, idx_b;
    logic                 twiddle;
    logic signed [DW-1:0] re_a, im_a, re_b, im_b;
    logic signed [DW:0]   sum_re, sum_im, dif_re, dif_im, dif_re_ba;
    logic signed [DW-1:0] up_re, up_im, lo_re, lo_im;

    assign idx_a   = {cnt_reg[1], 1'b0, cnt_reg[0]};
    assign idx_b   = {cnt_reg[1], 1'b1, cnt_reg[0]};
    assign twiddle = cnt_reg[0];

    always_comb begin
        re_a      = cap_re_reg[idx_a];
        im_a      = cap_im_reg[idx_a];
        re_b      = cap_re_reg[idx_b];
        im_b      = cap_im_reg[idx_b];
        sum_re    = {re_a[DW-1], re_a} + {re_b[DW-1], re_b};
        sum_im    = {im_a[DW-1], im_a} + {im_b[DW-1], im_b};
        dif_re    = {re_a[DW-1], re_a} - {re_b[DW-1], re_b};
        dif_im    = {im_a[DW-1], im_a} - {im_b[DW-1], im_b};
        dif_re_ba = {re_b[DW-1], re_b} - {re_a[DW-1], re_a};
        // Halving a DW+1 bit sum always fits back in DW bits, so truncation is exact.
        up_re     = DW'(sum_re >>> 1);
        up_im     = DW'(sum_im >>> 1);
        if (twiddle) begin
            lo_re = DW'(dif_im >>> 1);
            lo_im = DW'(dif_re_ba >>> 1);
        end else begin
            lo_re = DW'(dif_re >>> 1);
            lo_im = DW'(dif_im >>> 1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg   <= IDLE;
            cnt_reg     <= 2'd0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                cap_re_reg[i] <= '0;
                cap_im_reg[i] <= '0;
                out_re_reg[i] <= '0;
                out_im_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            done_reg  <= last;
            if (bus.stage1_done && state_reg == CALC)
                overrun_reg <= 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (accept) begin
                    cap_re_reg[i] <= bus.x_stage1_real[i];
                    cap_im_reg[i] <= bus.x_stage1_image[i];
                end
                if (calc_en && idx_a == 3'(i)) begin
                    out_re_reg[i] <= up_re;
                    out_im_reg[i] <= up_im;
                end
                if (calc_en && idx_b == 3'(i)) begin
                    out_re_reg[i] <= lo_re;
                    out_im_reg[i] <= lo_im;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_out
            assign bus.x_stage2_real[gi]  = out_re_reg[gi];
            assign bus.x_stage2_image[gi] = out_im_reg[gi];
        end
    endgenerate

    assign bus.stage2_done = done_reg;
    assign bus.busy        = (state_reg == CALC);
    assign bus.overrun     = overrun_reg;
endmodule

// File: tb/tb_fft_stage2_serial.sv
// Self-checking bench for fft_stage2_serial: directed vector table, random
// frames against a complex-arithmetic model, and reset/overrun/back-to-back sequences.
module tb_fft_stage2_serial;
    localparam int DW = 12;

    logic CLK;
    logic RESET;
    int   checks;
    int   failures;

    fft_stage2_serial_if #(.DW(DW)) bus ();

    fft_stage2_serial #(.DW(DW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int xr[8];
        int xi[8];
        int yr[8];
        int yi[8];
    } vec_t;

    vec_t tbl[5];

    function automatic vec_t zero_vec();
        vec_t v;
        for (int i = 0; i < 8; i++) begin
            v.xr[i] = 0; v.xi[i] = 0; v.yr[i] = 0; v.yi[i] = 0;
        end
        return v;
    endfunction

    // Reference: y[a] = (x[a]+x[b])/2, y[b] = (x[a]-x[b])*w/2 with w = -j for odd a.
    function automatic vec_t model(input vec_t v);
        int a, b, dr, di;
        for (int k = 0; k < 4; k++) begin
            a = (k < 2) ? k : k + 2;
            b = a + 2;
            v.yr[a] = (v.xr[a] + v.xr[b]) >>> 1;
            v.yi[a] = (v.xi[a] + v.xi[b]) >>> 1;
            dr = v.xr[a] - v.xr[b];
            di = v.xi[a] - v.xi[b];
            if (a % 2 == 1) begin
                v.yr[b] = di >>> 1;
                v.yi[b] = (-dr) >>> 1;
            end else begin
                v.yr[b] = dr >>> 1;
                v.yi[b] = di >>> 1;
            end
        end
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v = zero_vec();
        for (int i = 0; i < 8; i++) begin
            v.xr[i] = int'($urandom_range(4095)) - 2048;
            v.xi[i] = int'($urandom_range(4095)) - 2048;
        end
        return model(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    function automatic int nonzero_outputs();
        int n;
        n = 0;
        for (int i = 0; i < 8; i++)
            if (bus.x_stage2_real[i] != 0 || bus.x_stage2_image[i] != 0) n++;
        return n;
    endfunction

    task automatic scramble_inputs();
        for (int i = 0; i < 8; i++) begin
            bus.x_stage1_real[i]  = DW'($urandom);
            bus.x_stage1_image[i] = DW'($urandom);
        end
    endtask

    // Drive a start at the current negedge; returns at the negedge after the accept edge.
    task automatic start(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            bus.x_stage1_real[i]  = DW'(v.xr[i]);
            bus.x_stage1_image[i] = DW'(v.xi[i]);
        end
        bus.stage1_done = 1'b1;
        @(negedge CLK);
        bus.stage1_done = 1'b0;
        scramble_inputs();
    endtask

    task automatic check_outputs(input string name, input vec_t v);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s y%0d_re", name, i), int'(bus.x_stage2_real[i]), v.yr[i]);
            chk($sformatf("%s y%0d_im", name, i), int'(bus.x_stage2_image[i]), v.yi[i]);
        end
    endtask

    // Called right after start(): busy for 4 cycles, done in the 5th; ends on the done cycle.
    task automatic check_frame(input string name, input vec_t v);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("%s busy c%0d", name, c), int'(bus.busy), 1);
            chk($sformatf("%s done_low c%0d", name, c), int'(bus.stage2_done), 0);
            @(negedge CLK);
        end
        chk($sformatf("%s done_pulse", name), int'(bus.stage2_done), 1);
        chk($sformatf("%s busy_end", name), int'(bus.busy), 0);
        check_outputs(name, v);
        $display("frame %s checked at %0t", name, $time);
    endtask

    task automatic check_reset_state(input string name);
        chk($sformatf("%s outputs_zero", name), nonzero_outputs(), 0);
        chk($sformatf("%s busy", name), int'(bus.busy), 0);
        chk($sformatf("%s done", name), int'(bus.stage2_done), 0);
        chk($sformatf("%s overrun", name), int'(bus.overrun), 0);
    endtask

    initial begin
        vec_t v, w;
        int   pulses;

        checks   = 0;
        failures = 0;
        RESET    = 1'b1;
        bus.stage1_done = 1'b0;
        scramble_inputs();

        for (int i = 0; i < 5; i++) tbl[i] = zero_vec();
        tbl[0].xr[0] = 64;   tbl[0].yr[0] = 32;  tbl[0].yr[2] = 32;
        tbl[1].xr[1] = 40;   tbl[1].xi[1] = 20;  tbl[1].xr[3] = 10;  tbl[1].xi[3] = -30;
        tbl[1].yr[1] = 25;   tbl[1].yi[1] = -5;  tbl[1].yr[3] = 25;  tbl[1].yi[3] = -15;
        tbl[2].xr[4] = 2047; tbl[2].xr[6] = 2047; tbl[2].yr[4] = 2047;
        tbl[3].xr[4] = -2048; tbl[3].xr[6] = -2048; tbl[3].yr[4] = -2048;
        tbl[4].xr[5] = -3;   tbl[4].yr[5] = -2;  tbl[4].yi[7] = 1;

        repeat (2) @(negedge CLK);
        check_reset_state("reset_init");
        RESET = 1'b0;
        @(negedge CLK);

        // Directed vectors
        for (int t = 0; t < 5; t++) begin
            start(tbl[t]);
            check_frame($sformatf("tbl%0d", t), tbl[t]);
            @(negedge CLK);
            chk($sformatf("tbl%0d done_single", t), int'(bus.stage2_done), 0);
        end
        chk("overrun_clean", int'(bus.overrun), 0);

        // Random frames against the model
        for (int t = 0; t < 20; t++) begin
            v = rand_vec();
            repeat ($urandom_range(3)) @(negedge CLK);
            start(v);
            check_frame($sformatf("rand%0d", t), v);
            @(negedge CLK);
        end

        // Back-to-back: start accepted in the done cycle
        start(tbl[2]);
        check_frame("b2b_first", tbl[2]);
        start(tbl[1]);
        check_frame("b2b_second", tbl[1]);
        @(negedge CLK);
        chk("b2b done_single", int'(bus.stage2_done), 0);

        // Overrun: second start at T2 is ignored, sticky flag set
        chk("ovr before", int'(bus.overrun), 0);
        w = rand_vec();
        start(tbl[0]);
        for (int i = 0; i < 8; i++) begin
            bus.x_stage1_real[i]  = DW'(w.xr[i]);
            bus.x_stage1_image[i] = DW'(w.xi[i]);
        end
        bus.stage1_done = 1'b1;
        @(negedge CLK);
        bus.stage1_done = 1'b0;
        chk("ovr set", int'(bus.overrun), 1);
        repeat (3) @(negedge CLK);
        chk("ovr done_pulse", int'(bus.stage2_done), 1);
        check_outputs("ovr", tbl[0]);
        pulses = 0;
        repeat (8) begin
            @(negedge CLK);
            if (bus.stage2_done) pulses++;
        end
        chk("ovr extra_pulses", pulses, 0);
        chk("ovr sticky", int'(bus.overrun), 1);

        // Asynchronous reset mid-run with the start strobe toggling
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(1, 8)) begin
                bus.stage1_done = 1'($urandom);
                scramble_inputs();
                @(negedge CLK);
            end
            #($urandom_range(1, 4));
            RESET = 1'b1;
            #1;
            check_reset_state($sformatf("async_rst%0d", r));
            bus.stage1_done = 1'b0;
            @(negedge CLK);
            RESET = 1'b0;
            @(negedge CLK);
        end

        // Abort: reset before T2 of a frame, no done pulse, fresh frame works
        start(tbl[0]);
        @(negedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        check_reset_state("abort");
        @(negedge CLK);
        RESET = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge CLK);
            if (bus.stage2_done) pulses++;
        end
        chk("abort no_done", pulses, 0);
        v = rand_vec();
        start(v);
        check_frame("after_abort", v);
        @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
